// File: rtl/dp_feeder_pkg.sv
// Shared sizing constants and sequencer state encoding for the DP systolic feeder.
package dp_feeder_pkg;

   localparam int BP_WIDTH   = 2;
   localparam int N          = 64;
   localparam int LOG_N      = 6;
   localparam int ADDR_WIDTH = 10;
   localparam int JOBS_WIDTH = 16;

   typedef enum logic [2:0] {
      FEED_IDLE     = 3'd0,
      FEED_LOAD_S   = 3'd1,
      FEED_STREAM_T = 3'd2,
      FEED_DRAIN    = 3'd3,
      FEED_SWAP     = 3'd4,
      FEED_HOLD     = 3'd5
   } feed_state_t;

endpackage

// File: rtl/dp_feed_cnt.sv
// Loadable up/down counter whose terminal flag fires when the count equals term_val.
module dp_feed_cnt #(
   parameter int W    = 8,
   parameter bit DOWN = 1'b0
) (
   input  logic         clk,
   input  logic         reset_i,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] term_val,
   output logic         term
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt;

   // count register: load has priority over stepping
   always_ff @(posedge clk) begin
      if (reset_i) begin
         cnt <= {W{1'b0}};
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= DOWN ? (cnt - ONE) : (cnt + ONE);
      end else begin
         cnt <= cnt;
      end
   end

   assign term = (cnt == term_val);

endmodule

// File: rtl/dp_feeder.sv
// Job sequencer for the ping-pong DP wrapper: load S, stream T, drain, then swap banks
// only once traceback is idle.
module dp_feeder #(
   parameter int BP_WIDTH   = dp_feeder_pkg::BP_WIDTH,
   parameter int LOG_N      = dp_feeder_pkg::LOG_N,
   parameter int ADDR_WIDTH = dp_feeder_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_i,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [LOG_N-1:0]      job_s_len_m1,
   input  logic [ADDR_WIDTH-1:0] job_t_len_m1,
   input  logic                  s_in_valid,
   output logic                  s_in_ready,
   input  logic [BP_WIDTH-1:0]   s_in_data,
   input  logic                  t_in_valid,
   output logic                  t_in_ready,
   input  logic [BP_WIDTH-1:0]   t_in_data,
   output logic [BP_WIDTH-1:0]   dp_S,
   output logic                  dp_s_update,
   output logic [BP_WIDTH-1:0]   dp_T,
   output logic                  dp_valid,
   output logic [LOG_N-1:0]      dp_PE_end,
   output logic                  dp_new_seq,
   output logic                  dp_ack,
   input  logic                  dp_busy,
   input  logic                  tb_busy,
   output logic [15:0]           jobs_done
);

   import dp_feeder_pkg::*;

   // Drain covers the S-length PE pipeline plus the wrapper's two register stages.
   localparam logic [LOG_N:0] DRAIN_EXTRA = (LOG_N+1)'(2);

   feed_state_t           state;
   feed_state_t           next_state;
   logic [LOG_N-1:0]      s_len_m1;
   logic [ADDR_WIDTH-1:0] t_len_m1;
   logic                  job_acc;
   logic                  s_acc;
   logic                  t_acc;
   logic                  fire;
   logic                  drain_en;
   logic                  hold_en;
   logic                  s_term;
   logic                  t_term;
   logic                  drain_term;
   logic                  hold_term;
   logic                  drain_load;
   logic [LOG_N:0]        drain_init;

   assign drain_init = {1'b0, s_len_m1} + DRAIN_EXTRA;
   assign drain_load = t_acc & t_term;
   assign dp_PE_end  = s_len_m1;

   dp_feed_cnt #(.W(LOG_N), .DOWN(1'b0)) u_s_cnt (
      .clk(clk), .reset_i(reset_i), .load(job_acc), .load_val({LOG_N{1'b0}}),
      .en(s_acc), .term_val(s_len_m1), .term(s_term)
   );

   dp_feed_cnt #(.W(ADDR_WIDTH), .DOWN(1'b0)) u_t_cnt (
      .clk(clk), .reset_i(reset_i), .load(job_acc), .load_val({ADDR_WIDTH{1'b0}}),
      .en(t_acc), .term_val(t_len_m1), .term(t_term)
   );

   dp_feed_cnt #(.W(LOG_N+1), .DOWN(1'b1)) u_drain_cnt (
      .clk(clk), .reset_i(reset_i), .load(drain_load), .load_val(drain_init),
      .en(drain_en), .term_val((LOG_N+1)'(1)), .term(drain_term)
   );

   dp_feed_cnt #(.W(2), .DOWN(1'b1)) u_hold_cnt (
      .clk(clk), .reset_i(reset_i), .load(fire), .load_val(2'd2),
      .en(hold_en), .term_val(2'd1), .term(hold_term)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset_i) begin
         state <= FEED_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next-state, stream readies and accept strobes; readies are held low during reset
   always_comb begin
      next_state = state;
      job_ready  = 1'b0;
      s_in_ready = 1'b0;
      t_in_ready = 1'b0;
      job_acc    = 1'b0;
      s_acc      = 1'b0;
      t_acc      = 1'b0;
      fire       = 1'b0;
      drain_en   = 1'b0;
      hold_en    = 1'b0;
      if (reset_i) begin
         next_state = FEED_IDLE;
      end else begin
         case (state)
            FEED_IDLE: begin
               job_ready = 1'b1;
               if (job_valid) begin
                  job_acc    = 1'b1;
                  next_state = FEED_LOAD_S;
               end else begin
                  next_state = FEED_IDLE;
               end
            end
            FEED_LOAD_S: begin
               s_in_ready = 1'b1;
               s_acc      = s_in_valid;
               if (s_in_valid && s_term) begin
                  next_state = FEED_STREAM_T;
               end else begin
                  next_state = FEED_LOAD_S;
               end
            end
            FEED_STREAM_T: begin
               t_in_ready = !dp_busy;
               t_acc      = t_in_valid && !dp_busy;
               if (t_in_valid && !dp_busy && t_term) begin
                  next_state = FEED_DRAIN;
               end else begin
                  next_state = FEED_STREAM_T;
               end
            end
            FEED_DRAIN: begin
               drain_en = 1'b1;
               if (drain_term) begin
                  next_state = FEED_SWAP;
               end else begin
                  next_state = FEED_DRAIN;
               end
            end
            FEED_SWAP: begin
               if (!tb_busy) begin
                  fire       = 1'b1;
                  next_state = FEED_HOLD;
               end else begin
                  next_state = FEED_SWAP;
               end
            end
            FEED_HOLD: begin
               hold_en = 1'b1;
               if (hold_term) begin
                  next_state = FEED_IDLE;
               end else begin
                  next_state = FEED_HOLD;
               end
            end
            default: begin
               next_state = FEED_IDLE;
            end
         endcase
      end
   end

   // registered array-side outputs, job lengths and completion counter
   always_ff @(posedge clk) begin
      if (reset_i) begin
         dp_S        <= {BP_WIDTH{1'b0}};
         dp_s_update <= 1'b0;
         dp_T        <= {BP_WIDTH{1'b0}};
         dp_valid    <= 1'b0;
         dp_new_seq  <= 1'b0;
         dp_ack      <= 1'b0;
         jobs_done   <= 16'd0;
         s_len_m1    <= {LOG_N{1'b0}};
         t_len_m1    <= {ADDR_WIDTH{1'b0}};
      end else begin
         dp_S        <= s_acc ? s_in_data : dp_S;
         dp_s_update <= s_acc;
         dp_T        <= t_acc ? t_in_data : dp_T;
         dp_valid    <= t_acc;
         dp_new_seq  <= fire;
         dp_ack      <= fire;
         jobs_done   <= fire ? (jobs_done + 16'd1) : jobs_done;
         s_len_m1    <= job_acc ? job_s_len_m1 : s_len_m1;
         t_len_m1    <= job_acc ? job_t_len_m1 : t_len_m1;
      end
   end

endmodule

// File: tb/tb_dp_feeder.sv
// Randomized bench for dp_feeder against a timestamp/count based job model.
module tb_dp_feeder;
   import dp_feeder_pkg::*;

   typedef struct {
      int njobs;
      int bub;
      int busy;
      int tbp;
      bit tb_burst;
      bit jv_hold;
      bit rst_mid;
      int s_fix;
      int t_fix;
      bit lat;
   } scen_t;

   localparam int NSCEN = 8;
   scen_t scens [NSCEN] = '{
      '{1,  0,  0,  0, 1'b0, 1'b1, 1'b0,  3,  7, 1'b1},  // basic job, latency check
      '{2,  0, 30,  0, 1'b0, 1'b1, 1'b0,  3,  7, 1'b0},  // array back-pressure
      '{1,  0,  0,  0, 1'b1, 1'b1, 1'b0,  3,  7, 1'b0},  // 20-cycle traceback stall
      '{3, 50,  0,  0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0},  // input bubbles
      '{3,  0,  0,  0, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0},  // back-to-back
      '{2,  0,  0,  0, 1'b0, 1'b1, 1'b1,  3,  9, 1'b0},  // reset in STREAM_T
      '{1, 20, 20, 20, 1'b0, 1'b1, 1'b0, 63,  0, 1'b0},  // longest query, shortest target
      '{8, 30, 30, 40, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0}   // everything random
   };

   logic                  clk = 1'b0;
   logic                  reset_i;
   logic                  job_valid;
   logic                  job_ready;
   logic [LOG_N-1:0]      job_s_len_m1;
   logic [ADDR_WIDTH-1:0] job_t_len_m1;
   logic                  s_in_valid, s_in_ready;
   logic [BP_WIDTH-1:0]   s_in_data;
   logic                  t_in_valid, t_in_ready;
   logic [BP_WIDTH-1:0]   t_in_data;
   logic [BP_WIDTH-1:0]   dp_S, dp_T;
   logic                  dp_s_update, dp_valid, dp_new_seq, dp_ack;
   logic [LOG_N-1:0]      dp_PE_end;
   logic                  dp_busy, tb_busy;
   logic [15:0]           jobs_done;

   dp_feeder dut (
      .clk(clk), .reset_i(reset_i), .job_valid(job_valid), .job_ready(job_ready),
      .job_s_len_m1(job_s_len_m1), .job_t_len_m1(job_t_len_m1),
      .s_in_valid(s_in_valid), .s_in_ready(s_in_ready), .s_in_data(s_in_data),
      .t_in_valid(t_in_valid), .t_in_ready(t_in_ready), .t_in_data(t_in_data),
      .dp_S(dp_S), .dp_s_update(dp_s_update), .dp_T(dp_T), .dp_valid(dp_valid),
      .dp_PE_end(dp_PE_end), .dp_new_seq(dp_new_seq), .dp_ack(dp_ack),
      .dp_busy(dp_busy), .tb_busy(tb_busy), .jobs_done(jobs_done)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_pass   = 0;
   int    cyc      = 0;
   scen_t sc;
   int    jobs_left, next_s, next_t;
   bit    rst_done, force_reset;

   // reference model: job progress as counts and cycle stamps
   bit    m_active, m_fired;
   int    m_acc, m_slen, m_tlen, m_s_sent, m_t_sent, m_s_done, m_swap_start, m_fire;
   int    obs_s, obs_t;
   logic                e_s_upd, e_t_v, e_new, e_ack;
   logic [BP_WIDTH-1:0] e_S, e_T;
   logic [LOG_N-1:0]    e_pe;
   logic [15:0]         e_jobs;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic pick_lengths();
      next_s = (sc.s_fix >= 0) ? sc.s_fix : int'($urandom_range(0, 7));
      next_t = (sc.t_fix >= 0) ? sc.t_fix : int'($urandom_range(0, 15));
   endtask

   task automatic run_cycle();
      bit e_jr, e_sr, e_tr, fire, j_acc, s_acc, t_acc;
      @(negedge clk);
      reset_i      = force_reset;
      job_valid    = (jobs_left > 0) && (sc.jv_hold || ($urandom_range(0, 99) < 50));
      job_s_len_m1 = LOG_N'(next_s);
      job_t_len_m1 = ADDR_WIDTH'(next_t);
      s_in_valid   = ($urandom_range(0, 99) >= sc.bub);
      s_in_data    = BP_WIDTH'($urandom);
      t_in_valid   = ($urandom_range(0, 99) >= sc.bub);
      t_in_data    = BP_WIDTH'($urandom);
      dp_busy      = ($urandom_range(0, 99) < sc.busy);
      if (sc.tb_burst)
         tb_busy = m_active && (m_t_sent == m_tlen) && (cyc >= m_swap_start) && (cyc < m_swap_start + 20);
      else
         tb_busy = ($urandom_range(0, 99) < sc.tbp);
      if (sc.rst_mid && !rst_done && m_active && m_s_sent == m_slen && cyc > m_s_done && m_t_sent == 4) begin
         reset_i   = 1'b1;
         job_valid = 1'b1;
         rst_done  = 1'b1;
      end
      #1;
      // registered outputs
      check_val("dp_s_update", dp_s_update, e_s_upd);
      check_val("dp_S", dp_S, e_S);
      check_val("dp_valid", dp_valid, e_t_v);
      check_val("dp_T", dp_T, e_T);
      check_val("dp_new_seq", dp_new_seq, e_new);
      check_val("dp_ack", dp_ack, e_ack);
      check_val("jobs_done", jobs_done, e_jobs);
      check_val("dp_PE_end", dp_PE_end, e_pe);
      if (dp_s_update === 1'b1) obs_s++;
      if (dp_valid === 1'b1) obs_t++;
      if (dp_new_seq === 1'b1 && m_active) begin
         check_val("s_symbol_count", obs_s, m_slen);
         check_val("t_symbol_count", obs_t, m_tlen);
         if (sc.lat) check_val("job_latency", cyc - m_acc, 1 + m_slen + m_tlen + (m_slen + 1) + 1);
      end
      // combinational readies
      if (m_active && m_fired && cyc >= m_fire + 3) m_active = 1'b0;
      e_jr = !reset_i && !m_active;
      e_sr = !reset_i && m_active && cyc > m_acc && m_s_sent < m_slen;
      e_tr = !reset_i && m_active && m_s_sent == m_slen && cyc > m_s_done && m_t_sent < m_tlen && !dp_busy;
      fire = !reset_i && m_active && !m_fired && m_t_sent == m_tlen && cyc >= m_swap_start && !tb_busy;
      check_val("job_ready", job_ready, e_jr);
      check_val("s_in_ready", s_in_ready, e_sr);
      check_val("t_in_ready", t_in_ready, e_tr);
      j_acc = job_valid && e_jr;
      s_acc = s_in_valid && e_sr;
      t_acc = t_in_valid && e_tr;
      // expectations for the next cycle
      if (reset_i) begin
         m_active = 1'b0; m_fired = 1'b0;
         e_s_upd = 1'b0; e_t_v = 1'b0; e_new = 1'b0; e_ack = 1'b0;
         e_S = '0; e_T = '0; e_pe = '0; e_jobs = 16'd0;
         obs_s = 0; obs_t = 0;
      end else begin
         e_s_upd = s_acc;
         e_t_v   = t_acc;
         if (s_acc) e_S = s_in_data;
         if (t_acc) e_T = t_in_data;
         e_new = fire;
         e_ack = fire;
         if (fire) begin
            e_jobs  = e_jobs + 16'd1;
            m_fired = 1'b1;
            m_fire  = cyc;
         end
         if (s_acc) begin
            m_s_sent++;
            if (m_s_sent == m_slen) m_s_done = cyc;
         end
         if (t_acc) begin
            m_t_sent++;
            if (m_t_sent == m_tlen) m_swap_start = cyc + (m_slen + 1) + 1;
         end
         if (j_acc) begin
            m_active = 1'b1; m_fired = 1'b0; m_acc = cyc;
            m_slen = next_s + 1; m_tlen = next_t + 1;
            m_s_sent = 0; m_t_sent = 0; m_s_done = 1 << 30; m_swap_start = 1 << 30;
            e_pe = LOG_N'(next_s);
            obs_s = 0; obs_t = 0;
            jobs_left--;
            pick_lengths();
         end
      end
      cyc++;
   endtask

   initial begin
      reset_i = 1'b1; job_valid = 1'b0; job_s_len_m1 = '0; job_t_len_m1 = '0;
      s_in_valid = 1'b0; s_in_data = '0; t_in_valid = 1'b0; t_in_data = '0;
      dp_busy = 1'b0; tb_busy = 1'b0;
      e_s_upd = 1'b0; e_t_v = 1'b0; e_new = 1'b0; e_ack = 1'b0;
      e_S = '0; e_T = '0; e_pe = '0; e_jobs = 16'd0;
      m_active = 1'b0; m_fired = 1'b0; m_swap_start = 1 << 30;
      obs_s = 0; obs_t = 0;
      sc = scens[0]; jobs_left = 0; rst_done = 1'b0;
      repeat (2) @(posedge clk);
      force_reset = 1'b1;
      repeat (2) run_cycle();
      force_reset = 1'b0;
      for (int i = 0; i < NSCEN; i++) begin
         int budget;
         sc        = scens[i];
         jobs_left = sc.njobs;
         rst_done  = 1'b0;
         pick_lengths();
         budget = 0;
         while ((jobs_left > 0 || m_active) && budget < 4000) begin
            run_cycle();
            budget++;
         end
         check_val("scenario_complete", int'(jobs_left > 0 || m_active), 0);
         repeat (3) run_cycle();
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
